// File: rtl/lcd_bus_scheduler.sv
// HD44780 power-on sequencer and two-way arbiter
// in front of the LcdController byte port.
module lcd_bus_scheduler #(
  parameter int INIT_DELAY   = 50000,
  parameter int CLEAR_DELAY  = 2000,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic       clkLcd,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] core_data,
  output logic       core_rs,
  output logic       core_send,
  input  logic       core_busy,
  output logic [1:0] grant,
  output logic       init_done,
  output logic       err
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_ISSUE,
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    HOLD
  } state_t;

  localparam logic [31:0] INIT_LAST  = 32'(INIT_DELAY - 1);
  localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_DELAY - 1);
  localparam logic [31:0] BUSY_LAST  = 32'(BUSY_TIMEOUT - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        rr;
  logic        locked;

  logic        pick0;
  logic        pick1;
  logic        timeout;
  logic        fin;
  logic        clr_byte;
  logic        hold_done;
  logic        advance;
  logic        last_init;
  logic [2:0]  idx_nxt;
  logic [7:0]  rom_nxt;

  function automatic logic [7:0] rom(input logic [2:0] i);
    unique case (i)
      3'd0:    rom = 8'h33;
      3'd1:    rom = 8'h32;
      3'd2:    rom = 8'h28;
      3'd3:    rom = 8'h0C;
      3'd4:    rom = 8'h06;
      3'd5:    rom = 8'h01;
      default: rom = 8'h00;
    endcase
  endfunction

  // rr remembers the last requester served; a tie goes to the other one
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (locked) begin
      pick0 = grant[0] & req0;
      pick1 = grant[1] & req1;
    end else if (req0 & req1) begin
      pick0 = rr;
      pick1 = ~rr;
    end else begin
      pick0 = req0;
      pick1 = req1;
    end
  end

  assign timeout   = (state == WAIT_HI) && !core_busy
                     && (cnt == BUSY_LAST);
  assign fin       = timeout
                     || ((state == WAIT_LO) && !core_busy);
  assign clr_byte  = !core_rs
                     && ((core_data == 8'h01)
                     || (core_data == 8'h02));
  assign hold_done = (state == HOLD) && (cnt == CLEAR_LAST);
  assign advance   = (fin && !clr_byte) || hold_done;
  assign last_init = (idx == 3'd5);
  assign idx_nxt   = idx + 3'd1;
  assign rom_nxt   = rom(idx_nxt);

  always_ff @(posedge clkLcd or negedge reset) begin
    if (!reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      rr        <= 1'b0;
      locked    <= 1'b0;
      core_data <= '0;
      core_rs   <= 1'b0;
      core_send <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      grant     <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      core_send <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        PWR_WAIT: begin
          if (cnt == INIT_LAST) begin
            state     <= INIT_ISSUE;
            cnt       <= '0;
            idx       <= '0;
            core_data <= rom(3'd0);
            core_rs   <= 1'b0;
            core_send <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT_ISSUE, ISSUE: begin
          state <= WAIT_HI;
          cnt   <= 32'd1;
        end
        IDLE: begin
          if (pick0 | pick1) begin
            state     <= ISSUE;
            grant     <= {pick1, pick0};
            ack0      <= pick0;
            ack1      <= pick1;
            core_send <= 1'b1;
            core_data <= pick1 ? data1 : data0;
            core_rs   <= pick1 ? rs1 : rs0;
            locked    <= pick1 ? lock1 : lock0;
            rr        <= pick1;
          end
        end
        WAIT_HI: begin
          if (core_busy) state <= WAIT_LO;
          else cnt <= cnt + 32'd1;
        end
        WAIT_LO: begin
        end
        HOLD: cnt <= cnt + 32'd1;
        default: state <= PWR_WAIT;
      endcase
      if (fin) begin
        err <= timeout;
        cnt <= '0;
        if (!locked) grant <= 2'b00;
        if (clr_byte) state <= HOLD;
      end
      // byte fully done: next init byte, end of init, or back to arbitration
      if (advance) begin
        cnt <= '0;
        if (init_done) begin
          state <= IDLE;
        end else if (last_init) begin
          init_done <= 1'b1;
          state     <= IDLE;
        end else begin
          idx       <= idx_nxt;
          core_data <= rom_nxt;
          core_rs   <= 1'b0;
          core_send <= 1'b1;
          state     <= INIT_ISSUE;
        end
      end
    end
  end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Sequencer and arbiter in front of `LcdController`'s byte interface (`data_in`, `rs`, `send`, `busy`). After reset it runs the HD44780 4-bit power-on command sequence. It then shares the single LCD byte port between two requesters, for example the line refresher and a command source. Bursts such as a cursor-address byte plus 16 characters are made atomic with a per-requester lock.

## Interface
Parameters:
- `INIT_DELAY`, default 50000: cycles idle after reset release before the first init byte.
- `CLEAR_DELAY`, default 2000: extra wait cycles after any clear/home command completes.
- `BUSY_TIMEOUT`, default 255: maximum cycles to wait for `core_busy` to rise after `core_send`.

Ports:
- `clkLcd`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  byte request, held with data stable until ack.
- `lock0`, `lock1`  in  1  keep grant after this byte is accepted.
- `rs0`, `rs1`  in  1  register select: 0 = command, 1 = data.
- `data0`, `data1`  in  8  byte to send.
- `ack0`, `ack1`  out  1  one-cycle pulse when the byte is accepted.
- `core_data`  out  8  to `LcdController` `data_in`.
- `core_rs`  out  1  to `LcdController` `rs`.
- `core_send`  out  1  to `LcdController` `send`.
- `core_busy`  in  1  from `LcdController` `busy`.
- `grant`  out  2  one-hot current owner; 00 means none.
- `init_done`  out  1  high once the init sequence has completed.
- `err`  out  1  one-cycle pulse on busy timeout.

## Operation
- **Reset values:** `core_data`=0x00, `core_rs`=0, `core_send`=0, `ack0`/`ack1`=0, `grant`=00, `init_done`=0, `err`=0. The round-robin pointer points at requester 0.
- **States:** PWR_WAIT, INIT_ISSUE, IDLE, ISSUE, WAIT_HI, WAIT_LO, HOLD.
- **PWR_WAIT:** count `INIT_DELAY` cycles, then go to INIT_ISSUE with the init index at 0.
- **Init ROM:** 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01, all sent with rs=0.
  - INIT_ISSUE sends `ROM[idx]` and goes to WAIT_HI. Completion returns to INIT_ISSUE, or via HOLD for 0x01.
  - After index 5 completes, set `init_done`=1 and go to IDLE.
  - Requests are ignored (no ack) while `init_done`=0.
- **IDLE, lock held:** if a locked owner exists, only that owner's req is considered. The other requester waits regardless of priority.
- **IDLE, no lock:** round-robin. If both requesters are active, grant the one not served last. A single active requester wins immediately.
- **Accept (ISSUE, one cycle):**
  - Latch the requester's rs/data into `core_rs`/`core_data`.
  - Pulse its ack and pulse `core_send`.
  - Update the round-robin pointer to this requester.
  - Sample its lock: lock=1 keeps `grant`; lock=0 clears `grant` to 00 after the byte completes.
- **WAIT_HI:** wait for `core_busy`=1. If `BUSY_TIMEOUT` cycles pass without it, pulse `err`, then treat the byte as complete.
- **WAIT_LO:** wait for `core_busy`=0.
- **HOLD:** entered after completion of a command byte (rs=0) equal to 0x01 or 0x02. Wait `CLEAR_DELAY` cycles, then go to IDLE (or INIT_ISSUE during init). Other bytes go straight to IDLE.
- **Lock owner drops req:** the lock stays held. The other requester remains blocked until the owner sends a byte with lock=0. The owner holding a lock with no further traffic is a user protocol error and is not timed out.
- **Mid-operation reset:** asynchronous return to reset values and PWR_WAIT. The init sequence reruns in full.

## Timing
- From IDLE with req asserted, ack/`core_send` pulse in the next cycle (ISSUE).
- `core_data`/`core_rs` are registered. They are valid in the `core_send` cycle and stay stable until the next ISSUE.
- `core_send` is high for exactly one cycle per byte. It is never reasserted before `core_busy` has risen and fallen (or timed out).
- After `core_busy` falls, return to IDLE takes 1 cycle (WAIT_LO to IDLE). The next byte's send occurs 2 cycles after the busy fall at minimum.
- `grant` updates in the ISSUE cycle. It clears in the cycle the byte completes when the accepted lock was 0.
- `init_done` rises in the cycle after completion of the final HOLD. Minimum time from reset release is `INIT_DELAY` plus 6 byte transactions plus `CLEAR_DELAY`.
- Timeout counter: `err` pulses in cycle `BUSY_TIMEOUT` after `core_send` if busy never rose.

## Test plan
- **Reset and init.** Stub busy high for 3 cycles after each send, with `INIT_DELAY`=10 and `CLEAR_DELAY`=5. Required: sends 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01 with rs=0, a 5-cycle gap after 0x01, then `init_done`=1. `req0` held during init gets no ack.
- **Round-robin.** Hold `req0` and `req1` continuously with lock=0, data 0x41/0x42, rs=1. Required: `core_data` alternates 0x41, 0x42, 0x41, …, and each ack pulses once per byte.
- **Lock burst.** `req0` sends 0x80 (rs=0) followed by 16 data bytes, lock=1 on all but the last, while `req1` is held active. Required: all 17 bytes of requester 0 are contiguous before any `ack1`, and `grant` is 01 throughout.
- **Clear delay.** `req1` sends rs=0 0x01, then 0x41. Required: the 0x41 send occurs `CLEAR_DELAY`+2 cycles after the 0x01 busy fall.
- **Timeout.** Tie busy low after init. Required: `err` pulses `BUSY_TIMEOUT` cycles after the send and the next request is served.
- **Async reset mid-burst.** Pull `reset` low during WAIT_LO. Required: all outputs return to reset values immediately and the init sequence restarts on release.
